// File: rtl/bf_uart_rx_if.sv
// bf_uart_rx_if
// Byte hand-off between the UART receive FIFO and the BF core input port.
//   in_val     : head byte of the receive FIFO (8'h00 when empty)
//   in_valid   : receive FIFO holds at least one byte
//   in_reading : core takes the head byte on this clock edge
// master : the receiver side (drives in_val / in_valid)
// slave  : the core side (drives in_reading)
interface bf_uart_rx_if;
    logic [7:0] in_val;
    logic       in_valid;
    logic       in_reading;

    modport master (
        output in_val,
        output in_valid,
        input  in_reading
    );

    modport slave (
        input  in_val,
        input  in_valid,
        output in_reading
    );
endinterface

// File: rtl/bf_uart_rx.sv
// bf_uart_rx
// 8N1 UART receiver feeding a show-ahead receive FIFO for the BF core.
// Ports:
//   clock        : single clock, all state changes on its rising edge
//   reset_n      : asynchronous active-low reset
//   rx           : serial line, idle high, asynchronous to clock
//   in_port      : bf_uart_rx_if.master (in_val, in_valid, in_reading)
//   fifo_count   : number of bytes queued, 0..FIFO_DEPTH
//   rx_busy      : receiver is inside a frame (or waiting out a break)
//   overrun      : sticky, a byte was dropped because the FIFO was full
//   frame_error  : sticky, a stop bit was sampled low
//   clear_errors : synchronous clear of both sticky flags (a same-edge set wins)
module bf_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        rx,
    bf_uart_rx_if.master                in_port,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        rx_busy,
    output logic                        overrun,
    output logic                        frame_error,
    input  logic                        clear_errors
);

    localparam int BIT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] FULL_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] TICK_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] TICK_ONE  = BIT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic             sync1_r;
    logic             rxs_r;
    state_t           state_r;
    logic [BIT_W-1:0] tick_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overrun_r;
    logic             frame_error_r;

    logic             stop_sample_s;
    logic             push_s;
    logic             fe_set_s;
    logic             pop_s;
    logic             full_s;
    logic             accept_s;
    logic             ovr_set_s;

    // Two-flop synchroniser for the asynchronous rx pin; idles high out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx;
            rxs_r   <= sync1_r;
        end
    end

    // Stop-bit sample decides between pushing the byte and flagging a framing error.
    always_comb begin
        stop_sample_s = (state_r == ST_STOP) && (tick_r == FULL_LAST);
        if (stop_sample_s) begin
            push_s   = rxs_r;
            fe_set_s = ~rxs_r;
        end else begin
            push_s   = 1'b0;
            fe_set_s = 1'b0;
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        full_s    = (count_r == CNT_FULL);
        pop_s     = in_port.in_reading && (count_r != CNT_ZERO);
        accept_s  = push_s && (!full_s || pop_s);
        ovr_set_s = push_s && full_s && !pop_s;
    end

    // Receiver FSM; the bit timer restarts on every state change and every sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            tick_r  <= TICK_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tick_r <= TICK_ZERO;
                    if (!rxs_r) begin
                        state_r <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_r == HALF_LAST) begin
                        tick_r <= TICK_ZERO;
                        idx_r  <= 3'd0;
                        // A start bit that is high again by mid-bit was a glitch.
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_r == FULL_LAST) begin
                        tick_r         <= TICK_ZERO;
                        shift_r[idx_r] <= rxs_r;
                        if (idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_r == FULL_LAST) begin
                        tick_r <= TICK_ZERO;
                        // Leaving at mid-stop-bit lets a back-to-back start bit be seen.
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_BREAK;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_ONE;
                    end
                end
                ST_BREAK: begin
                    tick_r <= TICK_ZERO;
                    // Held-low line: wait for the line to recover, one error only.
                    if (rxs_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tick_r  <= TICK_ZERO;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a set on the same edge as clear_errors wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r     <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clear_errors) begin
                overrun_r <= 1'b0;
            end
            if (fe_set_s) begin
                frame_error_r <= 1'b1;
            end else if (clear_errors) begin
                frame_error_r <= 1'b0;
            end
        end
    end

    assign in_port.in_valid = (count_r != CNT_ZERO);
    assign in_port.in_val   = (count_r != CNT_ZERO) ? mem_r[rd_ptr_r] : 8'h00;
    assign fifo_count       = count_r;
    assign rx_busy          = (state_r != ST_IDLE);
    assign overrun          = overrun_r;
    assign frame_error      = frame_error_r;

endmodule

// File: tb/tb_bf_uart_rx.sv
module tb_bf_uart_rx;

    localparam int CLKS  = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    // Edge index of the stop-bit sample, counted from the edge before rx falls:
    // 2 synchroniser edges + 1 detect edge, then half a bit plus nine bits.
    localparam int PUSH_LAT = 3 + CLKS / 2 + 9 * CLKS;

    logic          clock        = 1'b0;
    logic          reset_n      = 1'b0;
    logic          rx           = 1'b1;
    logic          clear_errors = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          rx_busy;
    logic          overrun;
    logic          frame_error;

    bf_uart_rx_if in_if ();

    bf_uart_rx #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx           (rx),
        .in_port      (in_if),
        .fifo_count   (fifo_count),
        .rx_busy      (rx_busy),
        .overrun      (overrun),
        .frame_error  (frame_error),
        .clear_errors (clear_errors)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model: byte queue, sticky flags, and frame completions keyed by edge.
    logic [7:0] mq [$];
    bit         m_ovr = 1'b0;
    bit         m_fe  = 1'b0;
    logic [7:0] ev_byte [int];
    bit         ev_good [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Send one 8N1 frame starting now; registers the frame outcome with the model.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        ev_byte[cyc + PUSH_LAT] = b;
        ev_good[cyc + PUSH_LAT] = stop_bit;
        rx = 1'b0;
        repeat (CLKS) tick();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CLKS) tick();
        end
        rx = stop_bit;
        repeat (CLKS) tick();
    endtask

    // Model update on every rising edge.
    initial forever begin
        bit do_pop;
        bit ovr_set;
        bit fe_set;
        @(posedge clock);
        cyc = cyc + 1;
        if (!reset_n) begin
            mq.delete();
            m_ovr = 1'b0;
            m_fe  = 1'b0;
            ev_byte.delete();
            ev_good.delete();
        end else begin
            do_pop  = in_if.in_reading && (mq.size() > 0);
            ovr_set = 1'b0;
            fe_set  = 1'b0;
            if (do_pop) void'(mq.pop_front());
            if (ev_byte.exists(cyc)) begin
                if (!ev_good[cyc]) fe_set = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(ev_byte[cyc]);
                else ovr_set = 1'b1;
                ev_byte.delete(cyc);
                ev_good.delete(cyc);
            end
            m_ovr = ovr_set ? 1'b1 : (clear_errors ? 1'b0 : m_ovr);
            m_fe  = fe_set  ? 1'b1 : (clear_errors ? 1'b0 : m_fe);
        end
    end

    // Compare DUT outputs with the model on every falling edge outside reset.
    initial forever begin
        logic [15:0] act;
        logic [15:0] exp;
        logic [7:0]  head;
        @(negedge clock);
        if (reset_n) begin
            head = (mq.size() > 0) ? mq[0] : 8'h00;
            act  = {in_if.in_valid, in_if.in_val, fifo_count, overrun, frame_error};
            exp  = {(mq.size() > 0), head, CW'(mq.size()), m_ovr, m_fe};
            check("model", {16'h0, act}, {16'h0, exp});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe;
        in_if.in_reading = 1'b0;
        repeat (3) tick();

        check("rst_valid", in_if.in_valid, 0);
        check("rst_val", in_if.in_val, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_fe", frame_error, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single byte then a single pop
        send_frame(8'h41, 1'b1);
        rx = 1'b1;
        tick();
        check("one_valid", in_if.in_valid, 1);
        check("one_val", in_if.in_val, 8'h41);
        check("one_count", fifo_count, 1);
        in_if.in_reading = 1'b1;
        tick();
        in_if.in_reading = 1'b0;
        check("pop_valid", in_if.in_valid, 0);
        check("pop_val", in_if.in_val, 8'h00);

        // Two-cycle glitch on rx
        rx = 1'b0;
        tick();
        tick();
        rx = 1'b1;
        tick();
        tick();
        check("glitch_busy", rx_busy, 1);
        repeat (6) tick();
        check("glitch_idle", rx_busy, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_fe", frame_error, 0);

        // Overrun: 17 back-to-back bytes, no pops
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        rx = 1'b1;
        tick();
        check("ovr_count", fifo_count, 16);
        check("ovr_flag", overrun, 1);
        in_if.in_reading = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovr_pop", in_if.in_val, i);
            tick();
        end
        in_if.in_reading = 1'b0;
        check("ovr_empty", in_if.in_valid, 0);
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("ovr_clear", overrun, 0);

        // Refill, then collide a pop with the push of 0xAA while full
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        rx = 1'b1;
        tick();
        check("full_count", fifo_count, 16);
        check("full_head", in_if.in_val, 8'h00);
        pe = cyc + PUSH_LAT;
        fork
            send_frame(8'hAA, 1'b1);
            begin
                while (cyc < pe - 1) tick();
                in_if.in_reading = 1'b1;
                tick();
                in_if.in_reading = 1'b0;
            end
        join
        rx = 1'b1;
        tick();
        check("coll_count", fifo_count, 16);
        check("coll_ovr", overrun, 0);
        check("coll_head", in_if.in_val, 8'h01);
        in_if.in_reading = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("coll_pop", in_if.in_val, (i < 15) ? (i + 1) : 8'hAA);
            tick();
        end
        in_if.in_reading = 1'b0;
        check("coll_empty", fifo_count, 0);

        // Framing error with clear_errors on the same edge: the set must win
        pe = cyc + PUSH_LAT;
        fork
            send_frame(8'h55, 1'b0);
            begin
                while (cyc < pe - 1) tick();
                clear_errors = 1'b1;
                tick();
                clear_errors = 1'b0;
            end
        join
        tick();
        check("fe_set", frame_error, 1);
        check("fe_nopush", fifo_count, 0);
        check("fe_break_busy", rx_busy, 1);
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("fe_clear", frame_error, 0);
        repeat (40 * CLKS) tick();
        check("break_no_repeat", frame_error, 0);
        check("break_busy", rx_busy, 1);
        check("break_count", fifo_count, 0);
        rx = 1'b1;
        repeat (2 * CLKS) tick();
        check("break_exit", rx_busy, 0);
        send_frame(8'h33, 1'b1);
        rx = 1'b1;
        tick();
        check("after_break_val", in_if.in_val, 8'h33);
        check("after_break_cnt", fifo_count, 1);
        check("after_break_fe", frame_error, 0);

        // Another bad stop bit so the flags are set before the reset test
        send_frame(8'hF0, 1'b0);
        rx = 1'b1;
        repeat (4) tick();
        check("fe2_set", frame_error, 1);
        check("fe2_head", in_if.in_val, 8'h33);

        // Reset during data bit 4 of 0xC3
        begin
            logic [7:0] c3;
            c3 = 8'hC3;
            rx = 1'b0;
            repeat (CLKS) tick();
            for (int k = 0; k < 4; k++) begin
                rx = c3[k];
                repeat (CLKS) tick();
            end
            rx = c3[4];
            repeat (CLKS / 2) tick();
        end
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (2) tick();
        check("mid_rst_valid", in_if.in_valid, 0);
        check("mid_rst_val", in_if.in_val, 8'h00);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", rx_busy, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_fe", frame_error, 0);
        reset_n = 1'b1;
        repeat (2 * CLKS) tick();
        check("post_rst_busy", rx_busy, 0);
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        tick();
        check("post_rst_valid", in_if.in_valid, 1);
        check("post_rst_val", in_if.in_val, 8'hC3);
        check("post_rst_count", fifo_count, 1);
        check("post_rst_fe", frame_error, 0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
